// File: rtl/gpc_uart_tx.sv
// gpc_uart_tx: memory-mapped serial transmitter on the gpc_cpu bus.
// DATA register at BASE_ADDR queues a byte, STATUS at BASE_ADDR+1 reads
// {4'b0, overflow, busy, empty, full}; a store to STATUS clears overflow.
// Frames are 8N1, LSB first. Defining GPC_UART_TX_PARITY_EN inserts an
// even-parity bit between the data bits and the stop bit.
module gpc_uart_tx #(
  parameter logic [15:0] BASE_ADDR    = 16'h6000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  inout  wire  [7:0]  data,
  input  logic        rw,
  output logic        tx
);

  localparam int              AW           = $clog2(FIFO_DEPTH);
  localparam int              CW           = AW + 1;
  localparam logic [15:0]     LP_STAT_ADDR = BASE_ADDR + 16'd1;
  localparam logic [15:0]     LP_CNT_END   = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   LP_FULL      = CW'(FIFO_DEPTH);

`ifdef GPC_UART_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  logic [7:0]    r_hold_data;
  logic          r_hold_sel;
  logic          r_hit;
  logic          r_ovf;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  logic [15:0]   r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
`ifdef GPC_UART_TX_PARITY_EN
  logic          r_par;
`endif

  logic       w_commit;
  logic       w_push;
  logic       w_pop;
  logic       w_empty;
  logic       w_full;
  logic       w_busy;
  logic       w_cnt_end;
  logic       w_rd_stat;
  logic [7:0] w_status;

  // The CPU holds rw high while data settles, so the last captured value
  // wins; the store takes effect on the first edge after rw drops.
  assign w_commit  = r_hit && !rw;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == LP_FULL);
  assign w_push    = w_commit && !r_hold_sel && !w_full;
  assign w_pop     = (r_state == ST_IDLE) && !w_empty;
  assign w_busy    = (r_state != ST_IDLE);
  assign w_cnt_end = (r_cnt == LP_CNT_END);

  assign w_status  = {4'b0000, r_ovf, w_busy, w_empty, w_full};
  assign w_rd_stat = !rw && (address == LP_STAT_ADDR);
  assign data      = w_rd_stat ? w_status : 8'hzz;
  assign tx        = r_tx;

  // Track the latest store to either register while rw is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_data <= '0;
      r_hold_sel  <= 1'b0;
      r_hit       <= 1'b0;
    end else if (rw) begin
      if (address == BASE_ADDR || address == LP_STAT_ADDR) begin
        r_hold_data <= data;
        r_hold_sel  <= address[0];
        r_hit       <= 1'b1;
      end else begin
        r_hit <= 1'b0;
      end
    end else begin
      r_hit <= 1'b0;
    end
  end

  // Sticky overflow: set by a DATA store into a full FIFO, cleared by any STATUS store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_commit && r_hold_sel) begin
      r_ovf <= 1'b0;
    end else if (w_commit && w_full) begin
      r_ovf <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_hold_data;
    end
  end

  // FIFO pointers and occupancy; a push and pop on one edge leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Transmit FSM; tx is registered and updated on the edge that enters each bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
`ifdef GPC_UART_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_shift <= r_mem[r_rd_ptr];
`ifdef GPC_UART_TX_PARITY_EN
            r_par   <= ^r_mem[r_rd_ptr];
`endif
            r_cnt   <= '0;
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_cnt_end) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= ST_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (w_cnt_end) begin
            r_cnt   <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
`ifdef GPC_UART_TX_PARITY_EN
              r_tx    <= r_par;
              r_state <= ST_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
`endif
            end else begin
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
`ifdef GPC_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_cnt_end) begin
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
`endif
        ST_STOP: begin
          if (w_cnt_end) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
